// File: rtl/aes_mode_sequencer.sv
`default_nettype none
// aes_mode_sequencer: issues per-block AES mode microcode (ECB/CBC/PCBC/CFB/OFB/CTR) with block handshake.
// Optional macro AES_SEQ_TIMEOUT_EN: abort with err_code 10 when valid_AES takes AES_TIMEOUT cycles.
module aes_mode_sequencer #(
    parameter int  REG_SEL_W   = 2,
    parameter int  BLK_CNT_W   = 8,
    parameter int  AES_TIMEOUT = 64,
    localparam int CW_W        = 3*REG_SEL_W+5
) (
    input  logic                 ACLK,
    input  logic                 ARSTn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_mode,
    input  logic                 cmd_decrypt,
    input  logic [BLK_CNT_W-1:0] cmd_blocks,
    output logic                 enable_amba,
    output logic [CW_W-1:0]      control_word,
    output logic                 wr_control,
    input  logic                 valid_AES,
    output logic                 blk_req,
    input  logic                 blk_ack,
    output logic [BLK_CNT_W-1:0] blk_index,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code
);
    localparam int         START_BIT = 3;
    localparam int         TMO_W     = $clog2(AES_TIMEOUT) + 1;
    localparam logic [1:0] FS_XOR = 2'b00, FS_INC = 2'b01, FS_MOV = 2'b10;
    localparam logic [1:0] R0 = 2'd0, R1 = 2'd1, R2 = 2'd2, R3 = 2'd3;
`ifdef AES_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_BLK_SYNC, S_DONE, S_ERROR
    } state_t;

    state_t                  state_q;
    logic [2:0]              mode_q;
    logic                    decrypt_q;
    logic [BLK_CNT_W-1:0]    blocks_q;
    logic [BLK_CNT_W-1:0]    blk_index_q;
    logic [3:0][CW_W-1:0]    prog_q;
    logic [3:0][CW_W-1:0]    w_prog;
    logic [1:0]              pc_q;
    logic [1:0]              last_q;
    logic [1:0]              w_last;
    logic                    w_illegal;
    logic [CW_W-1:0]         cw_q;
    logic                    wr_q;
    logic                    error_q;
    logic [1:0]              err_code_q;
    logic [TMO_W-1:0]        tmo_q;

    // Field order: {sel_a, sel_b, sel_r, dest, start_aes, decrypt, fs}
    function automatic logic [CW_W-1:0] mk(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] d, input logic aes,
                                           input logic dec, input logic [1:0] fs);
        return {REG_SEL_W'(a), REG_SEL_W'(b), aes, REG_SEL_W'(d), aes, dec, fs};
    endfunction

    function automatic logic [CW_W-1:0] op_xor(input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
        return mk(a, b, d, 1'b0, 1'b0, FS_XOR);
    endfunction

    function automatic logic [CW_W-1:0] op_aes(input logic [1:0] a, input logic [1:0] d, input logic dec);
        return mk(a, R0, d, 1'b1, dec, FS_MOV);
    endfunction

    function automatic logic [CW_W-1:0] op_mov(input logic [1:0] a, input logic [1:0] d);
        return mk(a, R0, d, 1'b0, 1'b0, FS_MOV);
    endfunction

    always_comb begin
        w_prog    = '0;
        w_last    = 2'd2;
        w_illegal = 1'b0;
        case (mode_q)
            3'd0: begin
                w_prog[0] = op_aes(R0, R2, decrypt_q);
                w_last    = 2'd0;
            end
            3'd1: begin
                if (!decrypt_q) w_prog[2:0] = {op_mov(R2, R1), op_aes(R2, R2, 1'b0), op_xor(R1, R0, R2)};
                else            w_prog[2:0] = {op_mov(R0, R1), op_xor(R1, R2, R2), op_aes(R0, R2, 1'b1)};
            end
            3'd2: begin
                if (!decrypt_q) w_prog[2:0] = {op_xor(R2, R0, R1), op_aes(R2, R2, 1'b0), op_xor(R1, R0, R2)};
                else            w_prog[2:0] = {op_xor(R0, R2, R1), op_xor(R2, R1, R2), op_aes(R0, R2, 1'b1)};
            end
            // CFB and OFB always run the core forward
            3'd3: begin
                if (!decrypt_q) w_prog[2:0] = {op_mov(R2, R1), op_xor(R0, R1, R2), op_aes(R1, R1, 1'b0)};
                else            w_prog[2:0] = {op_mov(R0, R1), op_xor(R2, R0, R2), op_aes(R1, R2, 1'b0)};
            end
            3'd4: begin
                if (!decrypt_q) begin
                    w_prog[1:0] = {op_xor(R0, R1, R2), op_aes(R1, R1, 1'b0)};
                    w_last      = 2'd1;
                end else begin
                    w_prog[2:0] = {op_xor(R2, R0, R2), op_mov(R2, R1), op_aes(R1, R2, 1'b0)};
                end
            end
            3'd5: begin
                w_prog = {mk(R3, R0, R3, 1'b0, 1'b0, FS_INC), op_xor(R0, R2, R2),
                          op_aes(R2, R2, 1'b0), op_xor(R1, R3, R2)};
                w_last = 2'd3;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q     <= S_IDLE;
            mode_q      <= 3'd0;
            decrypt_q   <= 1'b0;
            blocks_q    <= '0;
            blk_index_q <= '0;
            prog_q      <= '0;
            pc_q        <= 2'd0;
            last_q      <= 2'd0;
            cw_q        <= '0;
            wr_q        <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'b00;
            tmo_q       <= '0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        mode_q      <= cmd_mode;
                        decrypt_q   <= cmd_decrypt;
                        blocks_q    <= cmd_blocks;
                        blk_index_q <= '0;
                        error_q     <= 1'b0;
                        err_code_q  <= 2'b00;
                        state_q     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_illegal) begin
                        err_code_q <= 2'b01;
                        state_q    <= S_ERROR;
                    end else if (blocks_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        prog_q  <= w_prog;
                        last_q  <= w_last;
                        pc_q    <= 2'd0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cw_q    <= prog_q[pc_q];
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!cw_q[START_BIT] || valid_AES) begin
                        cw_q[START_BIT] <= 1'b0;
                        wr_q            <= 1'b1;
                        if (pc_q == last_q) begin
                            state_q <= (blk_index_q == blocks_q - BLK_CNT_W'(1)) ? S_DONE : S_BLK_SYNC;
                        end else begin
                            pc_q    <= pc_q + 2'd1;
                            state_q <= S_ISSUE;
                        end
                    end else if (TMO_EN && (tmo_q == TMO_W'(AES_TIMEOUT - 1))) begin
                        cw_q       <= '0;
                        err_code_q <= 2'b10;
                        state_q    <= S_ERROR;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_BLK_SYNC: begin
                    if (blk_ack) begin
                        blk_index_q <= blk_index_q + BLK_CNT_W'(1);
                        pc_q        <= 2'd0;
                        state_q     <= S_ISSUE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                S_ERROR: begin
                    error_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign enable_amba  = !(state_q inside {S_DECODE, S_ISSUE, S_WAIT});
    assign blk_req      = (state_q == S_BLK_SYNC);
    assign done         = (state_q == S_DONE);
    assign control_word = cw_q;
    assign wr_control   = wr_q;
    assign blk_index    = blk_index_q;
    assign error        = error_q;
    assign err_code     = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_mode_sequencer.sv
`default_nettype none
// tb_aes_mode_sequencer: scoreboard bench; a mode-table model queues the expected strobes,
// block requests and done pulses, and a negedge monitor pops them as the DUT produces them.
module tb_aes_mode_sequencer;
    localparam int CW_W    = 11;
    localparam int EV_WR   = 0;
    localparam int EV_BLK  = 1;
    localparam int EV_DONE = 2;
    localparam logic [1:0] R0 = 2'd0, R1 = 2'd1, R2 = 2'd2, R3 = 2'd3;

    typedef struct { int kind; logic [31:0] val; } ev_t;

    logic            ACLK = 1'b0;
    logic            ARSTn = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_decrypt = 1'b0;
    logic [2:0]      cmd_mode = 3'd0;
    logic [7:0]      cmd_blocks = 8'd0;
    logic            valid_AES = 1'b0;
    logic            blk_ack = 1'b0;
    logic            cmd_ready, enable_amba, wr_control, blk_req, done, error;
    logic [CW_W-1:0] control_word;
    logic [7:0]      blk_index;
    logic [1:0]      err_code;

    int              checks = 0;
    int              failures = 0;
    ev_t             exp_q[$];
    logic [CW_W-1:0] prog[$];
    bit              aes_off = 1'b0;
    bit              blk_prev = 1'b0;
    logic            exp_error = 1'b0;
    logic [1:0]      exp_code = 2'b00;

    aes_mode_sequencer #(.REG_SEL_W(2), .BLK_CNT_W(8), .AES_TIMEOUT(64)) dut (
        .ACLK(ACLK), .ARSTn(ARSTn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_decrypt(cmd_decrypt), .cmd_blocks(cmd_blocks),
        .enable_amba(enable_amba), .control_word(control_word), .wr_control(wr_control),
        .valid_AES(valid_AES), .blk_req(blk_req), .blk_ack(blk_ack), .blk_index(blk_index),
        .done(done), .error(error), .err_code(err_code)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Strobed words: start_aes already cleared; sel_r/decrypt only on core operations
    function automatic logic [CW_W-1:0] enc(input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                                            input bit aes, input bit dec, input logic [1:0] fs);
        return {a, b, aes, d, 1'b0, dec, fs};
    endfunction
    function automatic logic [CW_W-1:0] fx(input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
        return enc(a, b, d, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [CW_W-1:0] fe(input logic [1:0] a, input logic [1:0] d);
        return enc(a, R0, d, 1'b1, 1'b0, 2'b10);
    endfunction
    function automatic logic [CW_W-1:0] fd(input logic [1:0] a, input logic [1:0] d);
        return enc(a, R0, d, 1'b1, 1'b1, 2'b10);
    endfunction
    function automatic logic [CW_W-1:0] fm(input logic [1:0] a, input logic [1:0] d);
        return enc(a, R0, d, 1'b0, 1'b0, 2'b10);
    endfunction
    function automatic logic [CW_W-1:0] fi(input logic [1:0] a, input logic [1:0] d);
        return enc(a, R0, d, 1'b0, 1'b0, 2'b01);
    endfunction

    task automatic build_prog(input logic [2:0] mode, input bit dec);
        prog.delete();
        case (mode)
            3'd0: prog = dec ? '{fd(R0, R2)} : '{fe(R0, R2)};
            3'd1: prog = dec ? '{fd(R0, R2), fx(R1, R2, R2), fm(R0, R1)}
                             : '{fx(R1, R0, R2), fe(R2, R2), fm(R2, R1)};
            3'd2: prog = dec ? '{fd(R0, R2), fx(R2, R1, R2), fx(R0, R2, R1)}
                             : '{fx(R1, R0, R2), fe(R2, R2), fx(R2, R0, R1)};
            3'd3: prog = dec ? '{fe(R1, R2), fx(R2, R0, R2), fm(R0, R1)}
                             : '{fe(R1, R1), fx(R0, R1, R2), fm(R2, R1)};
            3'd4: prog = dec ? '{fe(R1, R2), fm(R2, R1), fx(R2, R0, R2)}
                             : '{fe(R1, R1), fx(R0, R1, R2)};
            default: prog = '{fx(R1, R3, R2), fe(R2, R2), fx(R0, R2, R2), fi(R3, R3)};
        endcase
    endtask

    task automatic model_push(input logic [2:0] mode, input bit dec, input logic [7:0] blocks, input bit tmo);
        if (mode >= 3'd6) begin
            exp_error = 1'b1; exp_code = 2'b01;
        end else if (tmo) begin
            exp_error = 1'b1; exp_code = 2'b10;
        end else begin
            exp_error = 1'b0; exp_code = 2'b00;
            build_prog(mode, dec);
            for (int b = 0; b < int'(blocks); b++) begin
                foreach (prog[i]) exp_q.push_back('{EV_WR, 32'(prog[i])});
                if (b < int'(blocks) - 1) exp_q.push_back('{EV_BLK, 32'(b)});
            end
            exp_q.push_back('{EV_DONE, 32'd0});
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] act, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s unexpected event actual=%0h required=none", name, act);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, kind, e.kind);
            if (e.kind == kind) chk(name, act, e.val);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_enable_amba"}, 32'(enable_amba), 1);
        chk({tag, "_control_word"}, 32'(control_word), 0);
        chk({tag, "_wr_control"}, 32'(wr_control), 0);
        chk({tag, "_blk_req"}, 32'(blk_req), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_err_code"}, 32'(err_code), 0);
        chk({tag, "_blk_index"}, 32'(blk_index), 0);
    endtask

    task automatic issue_cmd(input logic [2:0] mode, input bit dec, input logic [7:0] blocks, input bit tmo);
        int n = 0;
        while (!cmd_ready && n < 2000) begin @(posedge ACLK); #1; n++; end
        chk("ready_before_cmd", 32'(cmd_ready), 1);
        model_push(mode, dec, blocks, tmo);
        cmd_mode = mode; cmd_decrypt = dec; cmd_blocks = blocks; cmd_valid = 1'b1;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] mode, input bit dec, input logic [7:0] blocks, input bit tmo);
        int n = 0;
        issue_cmd(mode, dec, blocks, tmo);
        while (!cmd_ready && n < 5000) begin
            cmd_valid = ($urandom_range(0, 7) == 0);
            if (cmd_valid) begin cmd_mode = 3'($urandom); cmd_blocks = 8'($urandom); end
            @(posedge ACLK); #1; n++;
        end
        cmd_valid = 1'b0;
        chk("cmd_completes", 32'(n < 5000), 1);
        chk("missing_events", exp_q.size(), 0);
        exp_q.delete();
        chk("error_after_cmd", 32'(error), 32'(exp_error));
        chk("err_code_after_cmd", 32'(err_code), 32'(exp_code));
        chk("amba_after_cmd", 32'(enable_amba), 1);
    endtask

    always @(negedge ACLK) begin
        if (ARSTn) begin
            if (wr_control) expect_ev(EV_WR, 32'(control_word), "strobe_cw");
            if (blk_req && !blk_prev) expect_ev(EV_BLK, 32'(blk_index), "blk_index");
            if (blk_req) chk("amba_in_blk_sync", 32'(enable_amba), 1);
            if (done) expect_ev(EV_DONE, 32'd0, "done");
        end
        blk_prev = blk_req;
    end

    // AES core stand-in: random latency, plus stray valid pulses while no core op is pending
    initial begin : aes_resp
        int d;
        forever begin
            @(posedge ACLK); #1;
            if (ARSTn && control_word[3] && !aes_off) begin
                if (exp_q.size() > 0 && exp_q[0].kind == EV_WR)
                    chk("issue_cw", 32'(control_word), exp_q[0].val | 32'h8);
                else begin
                    checks++; failures++;
                    $display("FAIL issue_cw actual=%0h required=queued strobe", control_word);
                end
                chk("amba_busy_in_wait", 32'(enable_amba), 0);
                chk("ready_busy_in_wait", 32'(cmd_ready), 0);
                d = $urandom_range(0, 6);
                repeat (d) begin @(posedge ACLK); #1; end
                valid_AES = 1'b1;
                @(posedge ACLK); #1;
                valid_AES = 1'b0;
            end else if (!control_word[3] && $urandom_range(0, 5) == 0) begin
                valid_AES = 1'b1;
                @(posedge ACLK); #1;
                valid_AES = 1'b0;
            end
        end
    end

    initial begin : host_resp
        int d;
        forever begin
            @(posedge ACLK); #1;
            if (blk_req) begin
                d = $urandom_range(0, 3);
                repeat (d) begin @(posedge ACLK); #1; end
                blk_ack = 1'b1;
                @(posedge ACLK); #1;
                blk_ack = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                blk_ack = 1'b1;
                @(posedge ACLK); #1;
                blk_ack = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n;
        repeat (3) @(posedge ACLK);
        #1;
        check_reset_vals("reset");
        ARSTn = 1'b1;
        @(posedge ACLK); #1;

        run_cmd(3'd0, 1'b0, 8'd1, 1'b0);
        run_cmd(3'd1, 1'b1, 8'd3, 1'b0);
        run_cmd(3'd5, 1'b0, 8'd2, 1'b0);
        run_cmd(3'd6, 1'b0, 8'd2, 1'b0);
        run_cmd(3'd0, 1'b0, 8'd1, 1'b0);
        run_cmd(3'd7, 1'b1, 8'd1, 1'b0);
        run_cmd(3'd2, 1'b0, 8'd0, 1'b0);

        // Abort a CFB program while it waits on the core
        issue_cmd(3'd3, 1'b0, 8'd3, 1'b0);
        n = 0;
        while (!control_word[3] && n < 200) begin @(posedge ACLK); #1; n++; end
        chk("cfb_wait_reached", 32'(control_word[3]), 1);
        #2 ARSTn = 1'b0;
        #1 check_reset_vals("async_reset");
        exp_q.delete();
        repeat (2) @(posedge ACLK);
        #3 ARSTn = 1'b1;
        @(posedge ACLK); #1;
        run_cmd(3'd3, 1'b1, 8'd2, 1'b0);

`ifdef AES_SEQ_TIMEOUT_EN
        aes_off = 1'b1;
        run_cmd(3'd0, 1'b0, 8'd2, 1'b1);
        aes_off = 1'b0;
        run_cmd(3'd4, 1'b1, 8'd1, 1'b0);
`endif

        for (int k = 0; k < 40; k++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            run_cmd(m, 1'($urandom), 8'($urandom_range(0, 4)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_mode_sequencer.md
Name: aes_mode_sequencer

Overview:
- Next-generation microcode sequencer for the AES peripheral.
- Accepts a mode command (ECB/CBC/PCBC/CFB/OFB/CTR, encrypt/decrypt) plus a block count.
- Issues per-block micro-instructions (control words) to the register-file/ALU/AES-core datapath and performs a block-boundary handshake with the AMBA side.
- Adds over the previous generation:
  - parametrised register-select width
  - multi-block bursts
  - explicit cmd/done handshake
  - unsupported-mode error reporting
  - optional AES-core timeout

Parameters:
- REG_SEL_W, 2, width of each register-select field (register file has 2**REG_SEL_W entries, minimum 2); CW_W = 3*REG_SEL_W+5.
- BLK_CNT_W, 8, width of block count and block index.
- AES_TIMEOUT, 64, cycles to wait for valid_AES before timeout error (used only with AES_SEQ_TIMEOUT_EN).

Ports:
- ACLK  in  1  clock, rising edge.
- ARSTn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&cmd_ready.
- cmd_mode  in  3  000 ECB, 001 CBC, 010 PCBC, 011 CFB, 100 OFB, 101 CTR, 110/111 illegal.
- cmd_decrypt  in  1  1 = decrypt program.
- cmd_blocks  in  BLK_CNT_W  number of blocks to process.
- enable_amba  out  1  1 = AMBA side owns registers; 0 = sequencer busy.
- control_word  out  CW_W  {sel_a, sel_b, sel_r, dest, start_aes, decrypt, fs[1:0]}.
- wr_control  out  1  one-cycle register-file write strobe for current control_word.
- valid_AES  in  1  AES core result valid.
- blk_req  out  1  block finished, host must unload r2 / load next r0.
- blk_ack  in  1  host done with block exchange.
- blk_index  out  BLK_CNT_W  index of block in progress (0-based).
- done  out  1  one-cycle pulse, command complete.
- error  out  1  sticky until next accepted command.
- err_code  out  2  01 illegal mode, 10 AES timeout, 00 none.

Behaviour:
- Reset (async, ARSTn=0): state IDLE, control_word=0, wr_control=0, blk_req=0, done=0, error=0, err_code=0, blk_index=0, cmd_ready=1, enable_amba=1. Reset mid-operation aborts the program immediately; no further strobes are issued.
- Field encodings:
  - fs: 00 XOR(a,b), 01 INC(a), 10 MOV(a).
  - sel_r: 0 ALU, 1 AES.
  - Registers r0..r3 are indices 0..3, zero-extended to REG_SEL_W.
- States:
  - IDLE: cmd_ready=1, enable_amba=1. On cmd_valid, latch mode/decrypt/blocks, clear error/err_code, go DECODE.
  - DECODE (1 cycle): load the program and its length into the instruction buffer (4 entries).
    - Illegal mode: go ERROR with err_code=01.
    - cmd_blocks==0: go DONE with no strobes.
  - ISSUE: drive control_word = instr[pc], wr_control=0, go WAIT.
  - WAIT:
    - start_aes=0: wr_control=1 for exactly one cycle.
    - start_aes=1: hold until valid_AES, then clear start_aes in control_word and assert wr_control for one cycle.
    - Then pc+1 to ISSUE, or at last instruction go to BLK_SYNC (blocks remaining) or DONE.
  - BLK_SYNC: blk_req=1, enable_amba=1. On blk_ack: blk_req=0, blk_index+1, pc=0, go ISSUE. Register contents (IV/counter in r1/r3) are preserved between blocks.
  - DONE: done=1 one cycle, go IDLE.
  - ERROR: error=1 one cycle into IDLE; error stays sticky.
- enable_amba=0 in DECODE, ISSUE and WAIT.
- Latency: ALU instruction = 2 cycles issue-to-strobe; AES instruction = 1 + AES latency + 1.
- Programs (encrypt / decrypt):
  - ECB: r2<-E(r0) / r2<-D(r0).
  - CBC: r2<-r1^r0; r2<-E(r2); r1<-r2 / r2<-D(r0); r2<-r1^r2; r1<-r0.
  - PCBC: r2<-r1^r0; r2<-E(r2); r1<-r2^r0 / r2<-D(r0); r2<-r2^r1; r1<-r0^r2.
  - CFB: r1<-E(r1); r2<-r0^r1; r1<-r2 / r2<-E(r1); r2<-r2^r0; r1<-r0.
  - OFB: r1<-E(r1); r2<-r0^r1 / r2<-E(r1); r1<-r2; r2<-r2^r0.
  - CTR (both): r2<-r1^r3; r2<-E(r2); r2<-r0^r2; r3<-INC(r3).
- Edge cases:
  - valid_AES during an ALU instruction or in IDLE: ignored.
  - blk_ack outside BLK_SYNC: ignored.
  - cmd_valid while busy: ignored (cmd_ready=0).
  - blk_index wraps modulo 2**BLK_CNT_W; it is not reached because blocks ≤ 2**BLK_CNT_W−1.

Optional Feature:
- AES_SEQ_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT while start_aes=1.
  - If it reaches AES_TIMEOUT without valid_AES: control_word=0, no wr_control, go ERROR with err_code=10, remaining blocks abandoned.
- Undefined: WAIT blocks indefinitely on valid_AES; err_code 10 is never produced.

Test Plan:
- ECB encrypt, cmd_blocks=1, valid_AES 10 cycles after issue -> control_word sel_b=0, dest=2, start_aes=1; one wr_control; done pulse; enable_amba back to 1.
- CBC decrypt, cmd_blocks=3, blk_ack 2 cycles after each blk_req -> 3×3 wr_control strobes; blk_req twice; blk_index 0,1,2; one done.
- CTR encrypt, cmd_blocks=2 -> fourth instruction is fs=01, dest=3 in each block; 8 strobes total.
- cmd_mode=110 -> no wr_control; error=1, err_code=01; next valid ECB command clears error.
- ARSTn low during WAIT of CFB -> all outputs at reset values asynchronously; a fresh command afterwards completes normally.
- AES_SEQ_TIMEOUT_EN, AES_TIMEOUT=64, valid_AES never asserted -> error=1, err_code=10 at cycle 64 of WAIT; no done pulse.
